// File: rtl/board_eval_pkg.sv
// Shared types, default weights and width helpers for the board evaluator.
package board_eval_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StReduce,
    StCalc,
    StDone
  } state_e;

  localparam int WMaxDef   = 178;
  localparam int WCumDef   = 525;
  localparam int WRelDef   = 198;
  localparam int WRoughDef = 284;
  localparam int WHoleDef  = 685;
  localparam int WLinesDef = -873;

  // Width holding 0..rows (heights, max, min, rel, lines).
  function automatic int unsigned hw_width(input int unsigned rows);
    return $clog2(rows + 1);
  endfunction

  // Width holding 0..rows*cols (cum, holes, rough).
  function automatic int unsigned cw_width(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/board_row_scan.sv
// Combinational single-row update for the board scan: column tops, heights, holes, full-row flag.
module board_row_scan
  import board_eval_pkg::*;
#(
  parameter int unsigned ROWS = 20,
  parameter int unsigned COLS = 10,
  parameter int unsigned HW   = hw_width(ROWS),
  parameter int unsigned RCW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int unsigned IW   = $clog2(COLS + 1)
) (
  input  logic [COLS-1:0] row_bits_i,
  input  logic [COLS-1:0] seen_i,
  input  logic [RCW-1:0]  r_i,
  output logic [COLS-1:0] seen_o,
  output logic [COLS-1:0] h_we_o,
  output logic [HW-1:0]   h_val_o,
  output logic [IW-1:0]   hole_inc_o,
  output logic            full_o
);

  // First occupied cell in a column fixes that column's height.
  assign seen_o  = seen_i | row_bits_i;
  assign h_we_o  = row_bits_i & ~seen_i;
  assign h_val_o = HW'(ROWS) - HW'(r_i);
  assign full_o  = &row_bits_i;

  // Count empty cells lying under a top cell found in an earlier row.
  always_comb begin
    hole_inc_o = '0;
    for (int c = 0; c < COLS; c++) begin
      if (seen_i[c] && !row_bits_i[c]) hole_inc_o = hole_inc_o + IW'(1);
    end
  end

endmodule

// File: rtl/board_evaluator.sv
// Multi-cycle Tetris board scorer: scan rows, reduce column heights, weighted sum, done pulse.
// Optional macro BOARD_EVAL_FEATURES_EN adds the 'features' output port.
module board_evaluator
  import board_eval_pkg::*;
#(
  parameter int unsigned ROWS    = 20,
  parameter int unsigned COLS    = 10,
  parameter int unsigned SCORE_W = 32,
  parameter int          W_MAX   = WMaxDef,
  parameter int          W_CUM   = WCumDef,
  parameter int          W_REL   = WRelDef,
  parameter int          W_ROUGH = WRoughDef,
  parameter int          W_HOLE  = WHoleDef,
  parameter int          W_LINES = WLinesDef
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_score,
  input  logic [ROWS*COLS-1:0] board,
  output logic                 busy,
  output logic                 recv_score,
  output logic [SCORE_W-1:0]   score
`ifdef BOARD_EVAL_FEATURES_EN
  ,
  output logic [6*cw_width(ROWS, COLS)-1:0] features
`endif
);

  localparam int unsigned HW  = hw_width(ROWS);
  localparam int unsigned CW  = cw_width(ROWS, COLS);
  localparam int unsigned RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CCW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned IW  = $clog2(COLS + 1);

  localparam logic signed [SCORE_W-1:0] WMaxS   = SCORE_W'(W_MAX);
  localparam logic signed [SCORE_W-1:0] WCumS   = SCORE_W'(W_CUM);
  localparam logic signed [SCORE_W-1:0] WRelS   = SCORE_W'(W_REL);
  localparam logic signed [SCORE_W-1:0] WRoughS = SCORE_W'(W_ROUGH);
  localparam logic signed [SCORE_W-1:0] WHoleS  = SCORE_W'(W_HOLE);
  localparam logic signed [SCORE_W-1:0] WLinesS = SCORE_W'(W_LINES);

  state_e               state_q, state_d;
  logic [ROWS*COLS-1:0] board_q, board_d;
  logic [COLS-1:0]      seen_q, seen_d;
  logic [HW-1:0]        h_q [COLS];
  logic [HW-1:0]        h_d [COLS];
  logic [RCW-1:0]       row_q, row_d;
  logic [CCW-1:0]       col_q, col_d;
  logic [CW-1:0]        holes_q, holes_d, cum_q, cum_d, rough_q, rough_d;
  logic [HW-1:0]        lines_q, lines_d, max_q, max_d, min_q, min_d, hprev_q, hprev_d;
  logic                 busy_q, busy_d, recv_q, recv_d;
  logic [SCORE_W-1:0]   score_q, score_d;

  // Row scan wiring
  logic [COLS-1:0] row_bits [ROWS];
  logic [COLS-1:0] scan_seen, scan_we;
  logic [HW-1:0]   scan_hval;
  logic [IW-1:0]   scan_hole_inc;
  logic            scan_full;

  // Reduce / MAC wiring
  logic [HW-1:0]              cur_h, rel, rough_inc;
  logic signed [SCORE_W-1:0] calc_score;

  // Split the latched board into rows for indexing by the row counter.
  always_comb begin
    for (int r = 0; r < ROWS; r++) row_bits[r] = board_q[COLS*r +: COLS];
  end

  board_row_scan #(
    .ROWS (ROWS),
    .COLS (COLS),
    .HW   (HW),
    .RCW  (RCW),
    .IW   (IW)
  ) u_row_scan (
    .row_bits_i (row_bits[row_q]),
    .seen_i     (seen_q),
    .r_i        (row_q),
    .seen_o     (scan_seen),
    .h_we_o     (scan_we),
    .h_val_o    (scan_hval),
    .hole_inc_o (scan_hole_inc),
    .full_o     (scan_full)
  );

  assign cur_h     = h_q[col_q];
  assign rough_inc = (cur_h >= hprev_q) ? (cur_h - hprev_q) : (hprev_q - cur_h);
  assign rel       = max_q - min_q;

  // Features are unsigned, so zero-extend before the signed weighted sum.
  assign calc_score = $signed(SCORE_W'(max_q))   * WMaxS
                    + $signed(SCORE_W'(cum_q))   * WCumS
                    + $signed(SCORE_W'(rel))     * WRelS
                    + $signed(SCORE_W'(rough_q)) * WRoughS
                    + $signed(SCORE_W'(holes_q)) * WHoleS
                    + $signed(SCORE_W'(lines_q)) * WLinesS;

  // Next-state, accumulator and output updates per FSM phase.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    seen_d  = seen_q;
    h_d     = h_q;
    row_d   = row_q;
    col_d   = col_q;
    holes_d = holes_q;
    cum_d   = cum_q;
    rough_d = rough_q;
    lines_d = lines_q;
    max_d   = max_q;
    min_d   = min_q;
    hprev_d = hprev_q;
    busy_d  = busy_q;
    recv_d  = 1'b0;
    score_d = score_q;
    case (state_q)
      StIdle: begin
        if (req_score) begin
          board_d = board;
          seen_d  = '0;
          for (int c = 0; c < COLS; c++) h_d[c] = '0;
          row_d   = '0;
          col_d   = '0;
          holes_d = '0;
          cum_d   = '0;
          rough_d = '0;
          lines_d = '0;
          max_d   = '0;
          min_d   = HW'(ROWS);
          hprev_d = '0;
          busy_d  = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        seen_d = scan_seen;
        for (int c = 0; c < COLS; c++) begin
          if (scan_we[c]) h_d[c] = scan_hval;
        end
        holes_d = holes_q + CW'(scan_hole_inc);
        if (scan_full) lines_d = lines_q + HW'(1);
        if (row_q == RCW'(ROWS - 1)) state_d = StReduce;
        else                         row_d   = row_q + RCW'(1);
      end
      StReduce: begin
        if (cur_h > max_q) max_d = cur_h;
        if (cur_h < min_q) min_d = cur_h;
        cum_d   = cum_q + CW'(cur_h);
        if (col_q != '0) rough_d = rough_q + CW'(rough_inc);
        hprev_d = cur_h;
        if (col_q == CCW'(COLS - 1)) state_d = StCalc;
        else                         col_d   = col_q + CCW'(1);
      end
      StCalc: begin
        score_d = calc_score;
        recv_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Datapath and output registers; reset aborts any evaluation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_q <= '0;
      seen_q  <= '0;
      for (int c = 0; c < COLS; c++) h_q[c] <= '0;
      row_q   <= '0;
      col_q   <= '0;
      holes_q <= '0;
      cum_q   <= '0;
      rough_q <= '0;
      lines_q <= '0;
      max_q   <= '0;
      min_q   <= '0;
      hprev_q <= '0;
      busy_q  <= 1'b0;
      recv_q  <= 1'b0;
      score_q <= '0;
    end else begin
      board_q <= board_d;
      seen_q  <= seen_d;
      h_q     <= h_d;
      row_q   <= row_d;
      col_q   <= col_d;
      holes_q <= holes_d;
      cum_q   <= cum_d;
      rough_q <= rough_d;
      lines_q <= lines_d;
      max_q   <= max_d;
      min_q   <= min_d;
      hprev_q <= hprev_d;
      busy_q  <= busy_d;
      recv_q  <= recv_d;
      score_q <= score_d;
    end
  end

  assign busy       = busy_q;
  assign recv_score = recv_q;
  assign score      = score_q;

`ifdef BOARD_EVAL_FEATURES_EN
  logic [6*CW-1:0] features_q;

  // Feature vector captured in the same cycle as the score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      features_q <= '0;
    end else if (state_q == StCalc) begin
      features_q <= {CW'(lines_q), holes_q, rough_q, CW'(rel), cum_q, CW'(max_q)};
    end
  end

  assign features = features_q;
`endif

endmodule
